// File: rtl/edge_pkg.sv
// Shared types and default sizing for the multi-channel edge event detector.
package edge_pkg;

   localparam int unsigned N_CH_DEF        = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned DEBOUNCE_W_DEF  = 4;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   // True when a committed transition to new_level is reportable under mode m.
   function automatic logic edge_qualify(input edge_mode_t m, input logic new_level);
      logic hit;
      hit = 1'b0;
      case (m)
         EDGE_RISE: hit = new_level;
         EDGE_FALL: hit = ~new_level;
         EDGE_BOTH: hit = 1'b1;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One channel: optional synchroniser, debounce counter, filtered level and
// registered one-cycle edge pulse on commit.
module edge_filter_ch
   import edge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_W  = DEBOUNCE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sig_i,
   input  edge_mode_t            mode_i,
   input  logic [DEBOUNCE_W-1:0] len_i,
   output logic                  level_o,
   output logic                  pulse_o
);

   logic                  s_c;
   logic                  f_q, f_d;
   logic                  pulse_q, pulse_d;
   logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_c = sig_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q, sync_d;

         always_comb begin
            sync_d    = sync_q;
            sync_d[0] = sig_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
               sync_d[i] = sync_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= sync_d;
         end

         assign s_c = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // ">=" lets a lowered debounce length commit at once instead of wrapping.
   always_comb begin
      f_d     = f_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (s_c == f_q) begin
         cnt_d = '0;
      end else if (cnt_q >= len_i) begin
         f_d     = s_c;
         cnt_d   = '0;
         pulse_d = edge_qualify(mode_i, s_c);
      end else begin
         cnt_d = cnt_q + DEBOUNCE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f_q     <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         f_q     <= f_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign level_o = f_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/edge_event_detector.sv
// N_CH edge detectors with sticky pending/overflow flags, masked clear and a
// single interrupt that tracks the OR of pending.
module edge_event_detector
   import edge_pkg::*;
#(
   parameter int unsigned N_CH        = N_CH_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_W  = DEBOUNCE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       signal_in,
   input  logic [2*N_CH-1:0]     mode,
   input  logic [DEBOUNCE_W-1:0] debounce_len,
   input  logic                  clr,
   input  logic [N_CH-1:0]       clr_mask,
   output logic [N_CH-1:0]       edge_pulse,
   output logic [N_CH-1:0]       level,
   output logic [N_CH-1:0]       pending,
   output logic [N_CH-1:0]       overflow,
   output logic                  irq
);

   logic [N_CH-1:0] pulse_w;
   logic [N_CH-1:0] level_w;
   logic [N_CH-1:0] clr_c;
   logic [N_CH-1:0] pending_q, pending_d;
   logic [N_CH-1:0] overflow_q, overflow_d;
   logic            irq_q, irq_d;

   generate
      for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
         edge_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
         ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sig_i   (signal_in[i]),
            .mode_i  (edge_mode_t'(mode[2*i +: 2])),
            .len_i   (debounce_len),
            .level_o (level_w[i]),
            .pulse_o (pulse_w[i])
         );
      end
   endgenerate

   // A new pulse always beats a coincident clear of the same channel.
   always_comb begin
      clr_c      = {N_CH{clr}} & clr_mask;
      pending_d  = (pending_q & ~clr_c) | pulse_w;
      overflow_d = (overflow_q & ~clr_c) | (pulse_w & pending_q & ~clr_c);
      irq_d      = |pending_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q  <= '0;
         overflow_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         irq_q      <= irq_d;
      end
   end

   assign edge_pulse = pulse_w;
   assign level      = level_w;
   assign pending    = pending_q;
   assign overflow   = overflow_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_edge_event_detector.sv
// Directed bench: stimulus queues expected pulses/state snapshots; a negedge
// monitor consumes them as the DUT produces output.
module tb_edge_event_detector;

   localparam int unsigned N  = 8;
   localparam int unsigned DW = 4;
   localparam int unsigned QD = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  signal_in;
   logic [2*N-1:0] mode;
   logic [DW-1:0] debounce_len;
   logic          clr;
   logic [N-1:0]  clr_mask;
   logic [N-1:0]  edge_pulse, level, pending, overflow;
   logic          irq;

   typedef struct { int unsigned cyc; logic [7:0] pulse; } pexp_t;
   typedef struct { int unsigned cyc; logic [7:0] lvl, pend, ovf; logic irq; } sexp_t;

   pexp_t       pq [QD];
   sexp_t       sq [QD];
   int unsigned pwr = 0, prd = 0, swr = 0, srd = 0;
   int unsigned cyc = 0;
   int unsigned vec_cnt = 0, err_cnt = 0;
   logic        done = 1'b0;

   edge_event_detector dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .signal_in    (signal_in),
      .mode         (mode),
      .debounce_len (debounce_len),
      .clr          (clr),
      .clr_mask     (clr_mask),
      .edge_pulse   (edge_pulse),
      .level        (level),
      .pending      (pending),
      .overflow     (overflow),
      .irq          (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_pulse(input int unsigned d, input logic [7:0] p);
      pq[pwr].cyc   = cyc + d;
      pq[pwr].pulse = p;
      pwr++;
   endtask

   task automatic exp_state(input logic [7:0] l, input logic [7:0] p,
                            input logic [7:0] o, input logic i);
      sq[swr].cyc  = cyc;
      sq[swr].lvl  = l;
      sq[swr].pend = p;
      sq[swr].ovf  = o;
      sq[swr].irq  = i;
      swr++;
   endtask

   task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
      vec_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, want);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (edge_pulse !== 8'h00) begin
         vec_cnt++;
         if (prd == pwr) begin
            err_cnt++;
            $display("FAIL pulse_unexpected cyc=%0d got=%h required=none", cyc, edge_pulse);
         end else begin
            if (edge_pulse !== pq[prd].pulse || cyc != pq[prd].cyc) begin
               err_cnt++;
               $display("FAIL pulse got=%h@%0d required=%h@%0d",
                        edge_pulse, cyc, pq[prd].pulse, pq[prd].cyc);
            end
            prd++;
         end
      end
      if (srd != swr && sq[srd].cyc == cyc) begin
         cmp("quiet_pulse", edge_pulse, 8'h00);
         cmp("level", level, sq[srd].lvl);
         cmp("pending", pending, sq[srd].pend);
         cmp("overflow", overflow, sq[srd].ovf);
         cmp("irq", {7'd0, irq}, {7'd0, sq[srd].irq});
         srd++;
      end
      if (done) begin
         vec_cnt++;
         if (prd != pwr) begin
            err_cnt++;
            $display("FAIL pulse_missing got=%0d required=%0d pulses", prd, pwr);
         end
         vec_cnt++;
         if (srd != swr) begin
            err_cnt++;
            $display("FAIL state_missing got=%0d required=%0d checks", srd, swr);
         end
         $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
         $finish;
      end
   end

   initial begin
      rst_n        = 1'b0;
      signal_in    = '0;
      mode         = 16'hFFC9;   // ch0 RISE, ch1 FALL, ch2 OFF, ch3..7 BOTH
      debounce_len = '0;
      clr          = 1'b0;
      clr_mask     = '0;
      tick(3);
      exp_state(8'h00, 8'h00, 8'h00, 1'b0);
      rst_n = 1'b1;
      tick(2);

      // ch0 RISE, L=0: pulse 3 edges after the change
      signal_in[0] = 1'b1; exp_pulse(3, 8'h01);
      tick(4);
      exp_state(8'h01, 8'h01, 8'h00, 1'b1);

      // ch4 BOTH, L=3: 2-cycle glitch rejected, then rise and fall at +6
      debounce_len = 4'd3;
      signal_in[4] = 1'b1; tick(2);
      signal_in[4] = 1'b0; tick(6);
      exp_state(8'h01, 8'h01, 8'h00, 1'b1);
      signal_in[4] = 1'b1; exp_pulse(6, 8'h10); tick(6);
      signal_in[4] = 1'b0; exp_pulse(6, 8'h10); tick(7);
      exp_state(8'h01, 8'h11, 8'h10, 1'b1);
      clr = 1'b1; clr_mask = 8'hFF; tick(1);
      clr = 1'b0; clr_mask = 8'h00;
      exp_state(8'h01, 8'h00, 8'h00, 1'b0);

      // ch1 FALL, ch2 OFF, L=1
      debounce_len = 4'd1;
      signal_in[2:1] = 2'b11; tick(5);
      exp_state(8'h07, 8'h00, 8'h00, 1'b0);
      signal_in[2:1] = 2'b00; exp_pulse(4, 8'h02); tick(5);
      exp_state(8'h01, 8'h02, 8'h00, 1'b1);

      // ch3 BOTH twice -> overflow; masked-clear corner cases
      signal_in[3] = 1'b1; exp_pulse(4, 8'h08); tick(6);
      signal_in[3] = 1'b0; exp_pulse(4, 8'h08); tick(5);
      exp_state(8'h01, 8'h0A, 8'h08, 1'b1);
      clr_mask = 8'hFF; tick(1);
      exp_state(8'h01, 8'h0A, 8'h08, 1'b1);
      clr = 1'b1; clr_mask = 8'h00; tick(1);
      exp_state(8'h01, 8'h0A, 8'h08, 1'b1);
      clr_mask = 8'h08; tick(1);
      clr = 1'b0; clr_mask = 8'h00;
      exp_state(8'h01, 8'h02, 8'h00, 1'b1);
      clr = 1'b1; clr_mask = 8'hFF; tick(1);
      clr = 1'b0; clr_mask = 8'h00;
      exp_state(8'h01, 8'h00, 8'h00, 1'b0);

      // ch0: clear coinciding with a new pulse while pending -> set wins
      signal_in[0] = 1'b0; tick(5);
      signal_in[0] = 1'b1; exp_pulse(4, 8'h01); tick(6);
      signal_in[0] = 1'b0; tick(6);
      exp_state(8'h00, 8'h01, 8'h00, 1'b1);
      signal_in[0] = 1'b1; exp_pulse(4, 8'h01); tick(4);
      clr = 1'b1; clr_mask = 8'h01; tick(1);
      clr = 1'b0; clr_mask = 8'h00;
      exp_state(8'h01, 8'h01, 8'h00, 1'b1);

      // ch5, L=5: reset at c=2 discards the count
      clr = 1'b1; clr_mask = 8'hFF; tick(1);
      clr = 1'b0; clr_mask = 8'h00;
      signal_in = '0; tick(5);
      debounce_len = 4'd5;
      signal_in[5] = 1'b1; tick(4);
      rst_n = 1'b0; tick(2);
      exp_state(8'h00, 8'h00, 8'h00, 1'b0);
      rst_n = 1'b1; exp_pulse(8, 8'h20); tick(9);
      exp_state(8'h20, 8'h20, 8'h00, 1'b1);

      tick(3);
      done = 1'b1;
      tick(4);
      $display("FAIL monitor_timeout got=running required=finished");
      $fatal(1);
   end

endmodule
